// File: rtl/btn_pkg.sv
// Shared defaults and width helper for the push-button debounce bank.
package btn_pkg;

    localparam int BTN_TICK_DIV_DEF      = 50000;
    localparam int BTN_SETTLE_DEF        = 10;
    localparam int BTN_REPEAT_DELAY_DEF  = 500;
    localparam int BTN_REPEAT_PERIOD_DEF = 100;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int btn_cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop sync, tick-based settle filter, press/release strobes, toggle, optional BTN_REPEAT_EN auto-repeat.
// Level/strobes change 2 sync cycles + SETTLE_TICKS ticks after a clean pin edge; no backpressure, strobes are fire-and-forget.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int SETTLE_TICKS        = BTN_SETTLE_DEF,
    parameter bit INVERT              = 1'b0,
    parameter int REPEAT_DELAY_TICKS  = BTN_REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD_TICKS = BTN_REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_toggle
);

    localparam int              CNT_W    = btn_cnt_w(SETTLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_TICKS - 1);

    logic             sync1;
    logic             sync2;
    logic             raw;
    logic             accept;
    logic             rpt_fire;
    logic [CNT_W-1:0] cnt;

    // Reset to the idle pin level so no phantom edge appears after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= INVERT;
            sync2 <= INVERT;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    assign raw    = sync2 ^ INVERT;
    assign accept = (raw != btn_level) && tick && (cnt == CNT_LAST);

`ifdef BTN_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                             REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
    localparam int RPT_W   = btn_cnt_w(RPT_MAX);

    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_next;
    logic [RPT_W-1:0] rpt_target;
    logic             rpt_armed;

    // A release accepted on the same tick wins over a repeat strobe.
    always_comb begin
        rpt_next   = rpt_cnt + 1'b1;
        rpt_target = rpt_armed ? RPT_W'(REPEAT_PERIOD_TICKS) : RPT_W'(REPEAT_DELAY_TICKS);
        rpt_fire   = btn_level && tick && !accept && (rpt_next == rpt_target);
    end

    always_ff @(posedge clk) begin
        if (rst || !btn_level) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (tick && !accept) begin
            if (rpt_fire) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b1;
            end else begin
                rpt_cnt   <= rpt_next;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_toggle  <= 1'b0;
        end else begin
            btn_press   <= rpt_fire;
            btn_release <= 1'b0;
            if (raw == btn_level) begin
                cnt <= '0;
            end else if (tick) begin
                if (accept) begin
                    btn_level <= raw;
                    cnt       <= '0;
                    if (raw) begin
                        btn_press  <= 1'b1;
                        btn_toggle <= ~btn_toggle;
                    end else begin
                        btn_release <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/btn_debounce_bank.sv
// Multi-channel button conditioner: shared tick prescaler feeding CHANNELS debounce channels (BTN_REPEAT_EN adds auto-repeat).
// Latency 2 + (SETTLE_TICKS-1)*TICK_DIV+1 .. SETTLE_TICKS*TICK_DIV cycles per edge; no backpressure.
module btn_debounce_bank
    import btn_pkg::*;
#(
    parameter int                  CHANNELS            = 4,
    parameter int                  TICK_DIV            = BTN_TICK_DIV_DEF,
    parameter int                  SETTLE_TICKS        = BTN_SETTLE_DEF,
    parameter logic [CHANNELS-1:0] INVERT              = '0,
    parameter int                  REPEAT_DELAY_TICKS  = BTN_REPEAT_DELAY_DEF,
    parameter int                  REPEAT_PERIOD_TICKS = BTN_REPEAT_PERIOD_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_toggle
);

    localparam int               DIV_W    = btn_cnt_w(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        btn_debounce_ch #(
            .SETTLE_TICKS        (SETTLE_TICKS),
            .INVERT              (INVERT[i]),
            .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
            .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .btn_in      (btn_in[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_toggle  (btn_toggle[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Directed + random stimulus for btn_debounce_bank, checked against a tick-counting reference model.
module tb_btn_debounce_bank;

    localparam int         CH = 2;
    localparam int         TD = 4;
    localparam int         ST = 3;
    localparam logic [1:0] INV = 2'b10;
    localparam int         RD = 5;
    localparam int         RP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] btn_in;
    logic [CH-1:0] btn_level, btn_press, btn_release, btn_toggle;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    btn_debounce_bank #(
        .CHANNELS            (CH),
        .TICK_DIV            (TD),
        .SETTLE_TICKS        (ST),
        .INVERT              (INV),
        .REPEAT_DELAY_TICKS  (RD),
        .REPEAT_PERIOD_TICKS (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_toggle  (btn_toggle)
    );

    // Reference model: pin history, tick from edges since reset, ticks seen in the current disagreement run.
    logic [CH-1:0] m_pin1 = INV, m_pin2 = INV;
    logic [CH-1:0] m_level = '0, m_press = '0, m_release = '0, m_toggle = '0;
    logic [CH-1:0] m_raw;
    int            m_edges = 0;
    int            m_run  [CH];
    int            m_held [CH];
    bit            m_tick;

    always @(posedge clk) begin
        if (rst) begin
            m_pin1 = INV; m_pin2 = INV; m_edges = 0;
            m_level = '0; m_press = '0; m_release = '0; m_toggle = '0;
            for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_held[c] = 0; end
        end else begin
            m_edges++;
            m_tick    = (m_edges % TD) == 0;
            m_raw     = m_pin2 ^ INV;
            m_press   = '0;
            m_release = '0;
            for (int c = 0; c < CH; c++) begin
                if (m_raw[c] == m_level[c]) m_run[c] = 0;
                else if (m_tick)            m_run[c]++;
                if (m_run[c] == ST) begin
                    m_run[c]   = 0;
                    m_level[c] = m_raw[c];
                    if (m_raw[c]) begin
                        m_press[c]  = 1'b1;
                        m_toggle[c] = ~m_toggle[c];
                        m_held[c]   = 0;
                    end else begin
                        m_release[c] = 1'b1;
                    end
                end else if (m_level[c] && m_tick) begin
                    m_held[c]++;
`ifdef BTN_REPEAT_EN
                    if (m_held[c] == RD || (m_held[c] > RD && (m_held[c] - RD) % RP == 0))
                        m_press[c] = 1'b1;
`endif
                end
            end
            m_pin2 = m_pin1;
            m_pin1 = btn_in;
        end
    end

    task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag);
        @(negedge clk);
        chk({tag, ".level"},   btn_level,   m_level);
        chk({tag, ".press"},   btn_press,   m_press);
        chk({tag, ".release"}, btn_release, m_release);
        chk({tag, ".toggle"},  btn_toggle,  m_toggle);
    endtask

    int   cnt_p, cnt_s, first;
    logic [CH-1:0] seen;
    logic t0;

    initial begin
        // Reset with both pins idle (ch1 active-low idles high).
        rst = 1'b1; btn_in = 2'b10;
        repeat (5) cyc("reset");
        rst = 1'b0;
        cnt_s = 0;
        for (int i = 0; i < 40; i++) begin
            cyc("post_reset");
            cnt_s += int'(btn_level != 0) + int'(btn_press != 0) + int'(btn_release != 0) + int'(btn_toggle != 0);
        end
        chk_int("post_reset_quiet", cnt_s, 0);

        // Clean press on ch0.
        btn_in[0] = 1'b1; first = 0; cnt_p = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc("press");
            if (btn_level[0] && first == 0) first = i;
            cnt_p += int'(btn_press[0]);
        end
        chk_int("press_latency_ok", int'(first >= 1 && first <= 14), 1);
        chk_int("press_once", cnt_p, 1);
        chk("press_toggle", btn_toggle, 2'b01);
        btn_in[0] = 1'b0; cnt_s = 0;
        for (int i = 0; i < 30; i++) begin
            cyc("release");
            cnt_s += int'(btn_release[0]);
        end
        chk_int("release_once", cnt_s, 1);
        chk("release_toggle_kept", btn_toggle, 2'b01);

        // Bounce every 3 cycles, then settle high.
        cnt_s = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_in[0] = ~btn_in[0];
            cyc("bounce");
            cnt_s += int'(btn_press[0]) + int'(btn_release[0]);
        end
        chk_int("bounce_no_strobe", cnt_s, 0);
        btn_in[0] = 1'b1; first = 0; cnt_p = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc("settle");
            if (btn_press[0] && first == 0) first = i;
            cnt_p += int'(btn_press[0]);
        end
        chk_int("settle_latency_ok", int'(first >= 1 && first <= 14), 1);
        chk_int("settle_press_once", cnt_p, 1);
        btn_in[0] = 1'b0;
        repeat (30) cyc("settle_rel");

        // Simultaneous press: ch0 high-active, ch1 low-active.
        btn_in = 2'b01; seen = '0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            cyc("simul");
            seen = btn_press;
        end
        chk("simul_press", seen, 2'b11);
        chk("simul_toggle", btn_toggle, 2'b11);
        btn_in = 2'b10;
        repeat (30) cyc("simul_rel");

        // Reset mid-count, pin held through reset.
        btn_in[0] = 1'b1;
        repeat (8) cyc("pre_rst");
        chk("pre_rst_no_level", btn_level, 2'b00);
        rst = 1'b1;
        repeat (3) cyc("mid_rst");
        chk("mid_rst_level", btn_level, 2'b00);
        rst = 1'b0; first = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc("after_rst");
            if (btn_level[0] && first == 0) first = i;
        end
        chk_int("after_rst_accept_edge", first, 12);
        btn_in[0] = 1'b0;
        repeat (30) cyc("after_rst_rel");

        // Random pin activity with mixed short and long holds.
        for (int n = 0; n < 40; n++) begin
            btn_in = 2'($urandom);
            repeat ($urandom_range(1, 24)) cyc("random");
        end
        btn_in = 2'b10;
        repeat (30) cyc("random_rel");

        // Long hold on ch0 for 60 ticks.
        t0 = btn_toggle[0]; cnt_p = 0;
        btn_in[0] = 1'b1;
        for (int i = 0; i < 60 * TD + 14; i++) begin
            cyc("hold");
            cnt_p += int'(btn_press[0]);
        end
        chk("hold_toggle_once", {1'b0, btn_toggle[0]}, {1'b0, ~t0});
`ifdef BTN_REPEAT_EN
        chk_int("hold_repeats_present", int'(cnt_p > 20), 1);
`else
        chk_int("hold_press_once", cnt_p, 1);
`endif
        btn_in[0] = 1'b0;
        repeat (30) cyc("hold_rel");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
